// File: rtl/bank_timing_tracker_pkg.sv
// rtl/bank_timing_tracker_pkg.sv - shared types for the DRAM bank timing tracker
package usertype;

  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTIVATING  = 2'd1,
    BANK_ACTIVE      = 2'd2,
    BANK_PRECHARGING = 2'd3
  } bank_trk_state_t;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } dram_cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bank_timing_tracker_bank_timer.sv
// rtl/bank_timing_tracker_bank_timer.sv - one bank: state machine, timing counters, open row
module bank_timer
  import usertype::*;
#(
  parameter int ROW_BITS = 13,
  parameter int T_RCD    = 11,
  parameter int T_RAS    = 28,
  parameter int T_RP     = 11,
  parameter int T_RTP    = 6,
  parameter int T_WTP    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                act,
  input  logic                rd,
  input  logic                wr,
  input  logic                pre,
  input  logic [ROW_BITS-1:0] row,
  output logic                act_ok,
  output logic                rw_ok,
  output logic                pre_ok,
  output logic                bank_open,
  output logic [ROW_BITS-1:0] stored_row
);

  localparam int T_MAX = max_int(max_int(max_int(T_RCD, T_RAS), max_int(T_RP, T_RTP)), T_WTP);
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] RCD_L = CW'(T_RCD - 1);
  localparam logic [CW-1:0] RAS_L = CW'(T_RAS - 1);
  localparam logic [CW-1:0] RP_L  = CW'(T_RP - 1);
  localparam logic [CW-1:0] RTP_L = CW'(T_RTP - 1);
  localparam logic [CW-1:0] WTP_L = CW'(T_WTP - 1);

  bank_trk_state_t state;
  logic [CW-1:0]   rcd_cnt, ras_cnt, rp_cnt, rtp_cnt, wtp_cnt;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  // State advances as its counter leaves 1, so the window ends exactly T cycles after the command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BANK_IDLE;
      rcd_cnt    <= '0;
      ras_cnt    <= '0;
      rp_cnt     <= '0;
      rtp_cnt    <= '0;
      wtp_cnt    <= '0;
      stored_row <= '0;
    end else begin
      rcd_cnt <= sat_dec(rcd_cnt);
      ras_cnt <= sat_dec(ras_cnt);
      rp_cnt  <= sat_dec(rp_cnt);
      rtp_cnt <= sat_dec(rtp_cnt);
      wtp_cnt <= sat_dec(wtp_cnt);
      case (state)
        BANK_IDLE: begin
          if (act) begin
            state      <= (T_RCD == 1) ? BANK_ACTIVE : BANK_ACTIVATING;
            rcd_cnt    <= RCD_L;
            ras_cnt    <= RAS_L;
            stored_row <= row;
          end
        end
        BANK_ACTIVATING: begin
          if (rcd_cnt <= CW'(1)) state <= BANK_ACTIVE;
        end
        BANK_ACTIVE: begin
          if (pre) begin
            state  <= (T_RP == 1) ? BANK_IDLE : BANK_PRECHARGING;
            rp_cnt <= RP_L;
          end else begin
            if (rd) rtp_cnt <= (rtp_cnt > RTP_L) ? rtp_cnt : RTP_L;
            if (wr) wtp_cnt <= (wtp_cnt > WTP_L) ? wtp_cnt : WTP_L;
          end
        end
        BANK_PRECHARGING: begin
          if (rp_cnt <= CW'(1)) state <= BANK_IDLE;
        end
        default: state <= BANK_IDLE;
      endcase
    end
  end

  assign act_ok    = (state == BANK_IDLE);
  assign rw_ok     = (state == BANK_ACTIVE);
  assign pre_ok    = (state == BANK_ACTIVE) && (ras_cnt == '0) && (rtp_cnt == '0) && (wtp_cnt == '0);
  assign bank_open = (state == BANK_ACTIVATING) || (state == BANK_ACTIVE);

endmodule

// File: rtl/bank_timing_tracker.sv
// rtl/bank_timing_tracker.sv - per-bank DRAM timing legality tracker (optional refresh: BANK_TRK_REFRESH_EN)
module bank_timing_tracker
  import usertype::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int ROW_BITS  = 13,
  parameter int T_RCD     = 11,
  parameter int T_RAS     = 28,
  parameter int T_RP      = 11,
  parameter int T_RTP     = 6,
`ifdef BANK_TRK_REFRESH_EN
  parameter int T_WTP     = 24,
  parameter int T_RFC     = 110
`else
  parameter int T_WTP     = 24
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_type,
  input  logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  input  logic [ROW_BITS-1:0]          cmd_row,
  input  logic [$clog2(NUM_BANKS)-1:0] q_bank,
  input  logic [ROW_BITS-1:0]          q_row,
`ifdef BANK_TRK_REFRESH_EN
  input  logic                         ref_valid,
  output logic                         ref_ok,
`endif
  output logic                         q_hit,
  output logic [NUM_BANKS-1:0]         act_ok,
  output logic [NUM_BANKS-1:0]         rw_ok,
  output logic [NUM_BANKS-1:0]         pre_ok,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         cmd_illegal
);

  dram_cmd_t            cmd_kind;
  logic                 ok_sel;
  logic                 cmd_legal;
  logic                 illegal_next;
  logic [NUM_BANKS-1:0] bank_dec;
  logic [NUM_BANKS-1:0] act_ok_raw;
  logic [ROW_BITS-1:0]  rows [NUM_BANKS];

  assign cmd_kind = dram_cmd_t'(cmd_type);

  always_comb begin
    bank_dec           = '0;
    bank_dec[cmd_bank] = 1'b1;
  end

  always_comb begin
    ok_sel = 1'b0;
    case (cmd_kind)
      CMD_ACT:        ok_sel = act_ok[cmd_bank];
      CMD_RD, CMD_WR: ok_sel = rw_ok[cmd_bank];
      CMD_PRE:        ok_sel = pre_ok[cmd_bank];
      default:        ok_sel = 1'b0;
    endcase
  end

  assign cmd_legal = cmd_valid && ok_sel;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    bank_timer #(
      .ROW_BITS (ROW_BITS),
      .T_RCD    (T_RCD),
      .T_RAS    (T_RAS),
      .T_RP     (T_RP),
      .T_RTP    (T_RTP),
      .T_WTP    (T_WTP)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .act        (cmd_legal && bank_dec[i] && (cmd_kind == CMD_ACT)),
      .rd         (cmd_legal && bank_dec[i] && (cmd_kind == CMD_RD)),
      .wr         (cmd_legal && bank_dec[i] && (cmd_kind == CMD_WR)),
      .pre        (cmd_legal && bank_dec[i] && (cmd_kind == CMD_PRE)),
      .row        (cmd_row),
      .act_ok     (act_ok_raw[i]),
      .rw_ok      (rw_ok[i]),
      .pre_ok     (pre_ok[i]),
      .bank_open  (bank_open[i]),
      .stored_row (rows[i])
    );
  end

  assign q_hit = bank_open[q_bank] && (rows[q_bank] == q_row);

`ifdef BANK_TRK_REFRESH_EN
  localparam int RFC_W = $clog2(T_RFC) + 1;
  logic [RFC_W-1:0] rfc_cnt;

  // A refresh needs every bank idle and the previous refresh window finished.
  assign ref_ok = (&act_ok_raw) && (rfc_cnt == '0);
  assign act_ok = (rfc_cnt == '0) ? act_ok_raw : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfc_cnt <= '0;
    end else if (ref_valid && ref_ok) begin
      rfc_cnt <= RFC_W'(T_RFC - 1);
    end else if (rfc_cnt != '0) begin
      rfc_cnt <= rfc_cnt - 1'b1;
    end
  end

  assign illegal_next = (cmd_valid && !ok_sel) || (ref_valid && !ref_ok);
`else
  assign act_ok       = act_ok_raw;
  assign illegal_next = cmd_valid && !ok_sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_illegal <= 1'b0;
    else     cmd_illegal <= illegal_next;
  end

endmodule

// File: tb/tb_bank_timing_tracker.sv
// tb/tb_bank_timing_tracker.sv - directed self-checking bench for bank_timing_tracker
module tb_bank_timing_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = 2'd0;
  logic [2:0]  cmd_bank = 3'd0;
  logic [12:0] cmd_row = 13'd0;
  logic [2:0]  q_bank = 3'd0;
  logic [12:0] q_row = 13'd0;
  logic        q_hit;
  logic [7:0]  act_ok, rw_ok, pre_ok, bank_open;
  logic        cmd_illegal;

  int vectors = 0;
  int miscompares = 0;

  bank_timing_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_type    (cmd_type),
    .cmd_bank    (cmd_bank),
    .cmd_row     (cmd_row),
    .q_bank      (q_bank),
    .q_row       (q_row),
    .q_hit       (q_hit),
    .act_ok      (act_ok),
    .rw_ok       (rw_ok),
    .pre_ok      (pre_ok),
    .bank_open   (bank_open),
    .cmd_illegal (cmd_illegal)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] ACT = 2'd0, RD = 2'd1, WR = 2'd2, PRE = 2'd3;

  // Drives one command for one cycle; returns one cycle later with the command captured.
  task automatic issue(input logic [1:0] t, input logic [2:0] b, input logic [12:0] r);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_bank  = b;
    cmd_row   = r;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q_bank = 3'd0;
    q_row  = 13'd0;
    wait_cycles(2);
    vectors++; if (act_ok !== 8'hFF) begin miscompares++; $display("FAIL reset_act_ok got %h want ff", act_ok); end
    vectors++; if (rw_ok !== 8'h00) begin miscompares++; $display("FAIL reset_rw_ok got %h want 00", rw_ok); end
    vectors++; if (pre_ok !== 8'h00) begin miscompares++; $display("FAIL reset_pre_ok got %h want 00", pre_ok); end
    vectors++; if (bank_open !== 8'h00) begin miscompares++; $display("FAIL reset_bank_open got %h want 00", bank_open); end
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL reset_q_hit got %b want 0", q_hit); end
    vectors++; if (cmd_illegal !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_illegal got %b want 0", cmd_illegal); end
    rst = 1'b0;
  endtask

  // ACT issued in the very first cycle after reset release; RD legal exactly T_RCD later.
  task automatic test_act_rcd();
    issue(ACT, 3'd2, 13'h155);
    vectors++; if (cmd_illegal !== 1'b0) begin miscompares++; $display("FAIL first_act_accepted got %b want 0", cmd_illegal); end
    vectors++; if (bank_open[2] !== 1'b1) begin miscompares++; $display("FAIL act_bank_open got %b want 1", bank_open[2]); end
    for (int k = 1; k <= 10; k++) begin
      vectors++;
      if (rw_ok[2] !== 1'b0) begin miscompares++; $display("FAIL rcd_window t0+%0d got %b want 0", k, rw_ok[2]); end
      if (k < 10) @(negedge clk);
    end
    @(negedge clk);
    vectors++; if (rw_ok[2] !== 1'b1) begin miscompares++; $display("FAIL rcd_done got %b want 1", rw_ok[2]); end
    q_bank = 3'd2; q_row = 13'h155; #1;
    vectors++; if (q_hit !== 1'b1) begin miscompares++; $display("FAIL q_hit_match got %b want 1", q_hit); end
    q_row = 13'h154; #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL q_hit_row_miss got %b want 0", q_hit); end
    q_bank = 3'd3; q_row = 13'h155; #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL q_hit_bank_miss got %b want 0", q_hit); end
  endtask

  task automatic test_pre_timing();
    apply_reset();
    issue(ACT, 3'd0, 13'h0AA);
    wait_cycles(26);
    vectors++; if (pre_ok[0] !== 1'b0) begin miscompares++; $display("FAIL pre_ok_t0p27 got %b want 0", pre_ok[0]); end
    issue(PRE, 3'd0, 13'h0);
    vectors++; if (cmd_illegal !== 1'b1) begin miscompares++; $display("FAIL early_pre_illegal got %b want 1", cmd_illegal); end
    vectors++; if (rw_ok[0] !== 1'b1) begin miscompares++; $display("FAIL early_pre_stays_active got %b want 1", rw_ok[0]); end
    vectors++; if (pre_ok[0] !== 1'b1) begin miscompares++; $display("FAIL pre_ok_t0p28 got %b want 1", pre_ok[0]); end
    issue(PRE, 3'd0, 13'h0);
    vectors++; if (cmd_illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_one_cycle got %b want 0", cmd_illegal); end
    vectors++; if (bank_open[0] !== 1'b0) begin miscompares++; $display("FAIL pre_closes_bank got %b want 0", bank_open[0]); end
    wait_cycles(9);
    vectors++; if (act_ok[0] !== 1'b0) begin miscompares++; $display("FAIL rp_window_t0p38 got %b want 0", act_ok[0]); end
    @(negedge clk);
    vectors++; if (act_ok[0] !== 1'b1) begin miscompares++; $display("FAIL rp_done_t0p39 got %b want 1", act_ok[0]); end
  endtask

  task automatic test_write_recovery();
    apply_reset();
    issue(ACT, 3'd1, 13'h001);
    wait_cycles(27);
    vectors++; if (pre_ok[1] !== 1'b1) begin miscompares++; $display("FAIL ras_met got %b want 1", pre_ok[1]); end
    issue(WR, 3'd1, 13'h0);
    vectors++; if (pre_ok[1] !== 1'b0) begin miscompares++; $display("FAIL wtp_start got %b want 0", pre_ok[1]); end
    wait_cycles(4);
    issue(RD, 3'd1, 13'h0);
    vectors++; if (cmd_illegal !== 1'b0) begin miscompares++; $display("FAIL rd_accepted got %b want 0", cmd_illegal); end
    wait_cycles(17);
    vectors++; if (pre_ok[1] !== 1'b0) begin miscompares++; $display("FAIL wtp_w23 got %b want 0", pre_ok[1]); end
    @(negedge clk);
    vectors++; if (pre_ok[1] !== 1'b1) begin miscompares++; $display("FAIL wtp_w24 got %b want 1", pre_ok[1]); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    issue(ACT, 3'd3, 13'h033);
    issue(ACT, 3'd5, 13'h055);
    vectors++; if (cmd_illegal !== 1'b0) begin miscompares++; $display("FAIL b2b_act_accepted got %b want 0", cmd_illegal); end
    wait_cycles(8);
    vectors++; if (rw_ok !== 8'h00) begin miscompares++; $display("FAIL b2b_t0p10 got %h want 00", rw_ok); end
    @(negedge clk);
    vectors++; if (rw_ok !== 8'h08) begin miscompares++; $display("FAIL b2b_t0p11 got %h want 08", rw_ok); end
    @(negedge clk);
    vectors++; if (rw_ok !== 8'h28) begin miscompares++; $display("FAIL b2b_t0p12 got %h want 28", rw_ok); end
    vectors++; if (act_ok !== 8'hD7) begin miscompares++; $display("FAIL b2b_act_ok got %h want d7", act_ok); end
  endtask

  task automatic test_illegal();
    issue(RD, 3'd7, 13'h0);
    vectors++; if (cmd_illegal !== 1'b1) begin miscompares++; $display("FAIL rd_idle_illegal got %b want 1", cmd_illegal); end
    vectors++; if (bank_open[7] !== 1'b0) begin miscompares++; $display("FAIL rd_idle_no_change got %b want 0", bank_open[7]); end
    issue(ACT, 3'd3, 13'h111);
    vectors++; if (cmd_illegal !== 1'b1) begin miscompares++; $display("FAIL act_open_illegal got %b want 1", cmd_illegal); end
    q_bank = 3'd3; q_row = 13'h033; #1;
    vectors++; if (q_hit !== 1'b1) begin miscompares++; $display("FAIL act_open_row_kept got %b want 1", q_hit); end
    @(negedge clk);
    vectors++; if (cmd_illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_clears got %b want 0", cmd_illegal); end
  endtask

  task automatic test_reset_mid_count();
    apply_reset();
    issue(ACT, 3'd4, 13'h044);
    wait_cycles(27);
    issue(PRE, 3'd4, 13'h0);
    wait_cycles(5);
    vectors++; if (act_ok[4] !== 1'b0 || bank_open[4] !== 1'b0) begin
      miscompares++; $display("FAIL precharging_state got act_ok=%b open=%b want 0/0", act_ok[4], bank_open[4]);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (act_ok !== 8'hFF) begin miscompares++; $display("FAIL mid_reset_act_ok got %h want ff", act_ok); end
    vectors++; if (bank_open !== 8'h00) begin miscompares++; $display("FAIL mid_reset_bank_open got %h want 00", bank_open); end
    rst = 1'b0;
    issue(ACT, 3'd4, 13'h044);
    vectors++; if (cmd_illegal !== 1'b0 || bank_open[4] !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_act got illegal=%b open=%b want 0/1", cmd_illegal, bank_open[4]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_act_rcd();
    test_pre_timing();
    test_write_recovery();
    test_back_to_back();
    test_illegal();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bank_timing_tracker.md
BANK_TIMING_TRACKER -- requirements
Module: bank_timing_tracker

Interface
REQ-001 Parameters (name, default, meaning): NUM_BANKS, 8, bank count (power of two, 2..16).
REQ-002 ROW_BITS, 13, row address width.
REQ-003 T_RCD, 11; T_RAS, 28; T_RP, 11; T_RTP, 6; T_WTP, 24: ACT-to-RD/WR, ACT-to-PRE, PRE-to-ACT, RD-to-PRE and WR-to-PRE minimum spacing in cycles; each SHALL be >= 1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 cmd_valid  in  1  command issued this cycle.
REQ-007 cmd_type  in  2  0 ACT, 1 RD, 2 WR, 3 PRE.
REQ-008 cmd_bank  in  $clog2(NUM_BANKS)  target bank.
REQ-009 cmd_row  in  ROW_BITS  row for ACT; ignored otherwise.
REQ-010 q_bank/q_row  in  $clog2(NUM_BANKS)/ROW_BITS  row-hit query.
REQ-011 q_hit  out  1  combinational: q_bank ACTIVE or ACTIVATING with stored row == q_row.
REQ-012 act_ok, rw_ok, pre_ok  out  NUM_BANKS each  per-bank legality of ACT, RD/WR, PRE this cycle.
REQ-013 bank_open  out  NUM_BANKS  bank not IDLE and not PRECHARGING.
REQ-014 cmd_illegal  out  1  registered pulse, one cycle after a rejected command.

Function
REQ-015 Per-bank FSM states: IDLE, ACTIVATING, ACTIVE, PRECHARGING; one instance per bank; only the addressed bank reacts.
REQ-016 Legal command = cmd_valid and the matching ok bit of cmd_bank is 1; a rejected command SHALL cause no state/counter change and SHALL set cmd_illegal for exactly the next cycle.
REQ-017 ACT in IDLE: -> ACTIVATING, rcd_cnt=T_RCD-1, ras_cnt=T_RAS-1, store cmd_row.
REQ-018 ACTIVATING -> ACTIVE on the edge where rcd_cnt==0; earliest legal RD/WR is exactly T_RCD cycles after the ACT cycle.
REQ-019 RD in ACTIVE: rtp_cnt=max(rtp_cnt,T_RTP-1); WR in ACTIVE: wtp_cnt=max(wtp_cnt,T_WTP-1); state stays ACTIVE.
REQ-020 PRE legal only in ACTIVE with ras_cnt, rtp_cnt and wtp_cnt all 0: -> PRECHARGING, rp_cnt=T_RP-1.
REQ-021 PRECHARGING -> IDLE on the edge where rp_cnt==0; earliest next ACT is exactly T_RP cycles after PRE.
REQ-022 All counters decrement by 1 per cycle, saturate at 0, never wrap; width $clog2(max timing)+1.
REQ-023 act_ok = IDLE; rw_ok = ACTIVE; pre_ok per REQ-020; all decoded from registered state only, no cmd_* input path.
REQ-024 T_RCD=1: rw_ok asserts the cycle after ACT; T_RP=1: act_ok the cycle after PRE.

Reset
REQ-025 rst asserted (any time, including mid-count): every bank IDLE, all counters 0, stored rows 0, cmd_illegal 0; hence act_ok all 1, rw_ok/pre_ok/bank_open all 0, q_hit 0.
REQ-026 First command is accepted in the first cycle after rst deasserts.

Configuration
REQ-027 Macro BANK_TRK_REFRESH_EN: when defined, cmd_type 3 with cmd_bank ignored is reinterpreted only via extra input ref_valid (1 bit) and parameter T_RFC (default 110); refresh legal only when all banks IDLE, output ref_ok (1 bit) reports this; accepted refresh forces act_ok to all 0 for T_RFC cycles; illegal refresh pulses cmd_illegal.
REQ-028 Without the macro: no ref_valid/ref_ok ports, no T_RFC counter; behaviour per REQ-015..024 only.

Structure
REQ-029 Bank FSM enum (bank_trk_state_t) and command-type enum (dram_cmd_t, ACT/RD/WR/PRE) SHALL live in package usertype.
REQ-030 One sub-module bank_timer (one bank: FSM, counters, stored row) instantiated NUM_BANKS times via generate; top holds decode, q_hit mux, cmd_illegal register, optional refresh counter.

Verification
REQ-031 Reset, ACT bank 2 row 0x155 at t0 -> rw_ok[2]=0 through t0+10, 1 at t0+11; q_hit=1 for (2,0x155), 0 for (2,0x154).
REQ-032 ACT bank 0 at t0, PRE bank 0 at t0+27 -> rejected, cmd_illegal=1 at t0+28, bank stays ACTIVE; PRE at t0+28 accepted, act_ok[0]=1 at t0+39.
REQ-033 WR bank 1 at cycle w (after tRAS met) -> pre_ok[1]=0 until w+23, 1 at w+24; RD in between does not shorten it.
REQ-034 Interleave ACT bank 3 and bank 5 on consecutive cycles -> independent timing, bank 5 rw_ok rises one cycle after bank 3.
REQ-035 Assert rst while bank 4 PRECHARGING with rp_cnt=5 -> next cycle act_ok all 1, bank_open all 0.
REQ-036 With BANK_TRK_REFRESH_EN: refresh with bank 6 open -> cmd_illegal=1; all IDLE, refresh at r -> act_ok all 0 through r+109, all 1 at r+110.
